// File: rtl/ice51_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ice51_pkg
// Description : Shared types and constants for the ice51 boot-load path.
//               Boot FSM state encoding, the fixed drain length and the
//               default code-memory geometry used by the boot controller
//               and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package ice51_pkg;

  // Boot controller states
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } boot_state_t;

  // Cycles spent in DRAIN so the final write commits before the first fetch
  localparam int DRAIN_CYCLES = 2;

  // Default code-memory geometry
  localparam int DEFAULT_MEM_SIZE = 512;
  localparam int DEFAULT_ADDR_W   = 9;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ice51_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ice51_boot_ctrl
// Description : Boot-load controller for the ice51 core. Streams UART RX
//               bytes sequentially into code memory while holding the CPU
//               in reset, waits a short drain period, then hands the
//               code-memory address port to the CPU and releases it.
// Revision    : 1.0 - initial release
//
// Ports:
//   i_clk        clock
//   i_nrst       reset, asynchronous, active-high
//   i_rx_valid   one-cycle pulse: UART RX byte available
//   i_rx_data    UART RX byte, valid with i_rx_valid
//   i_reload     one-cycle pulse: restart the boot load (honoured in RUN)
//   i_cpu_addr   CPU fetch address
//   o_mem_we     code memory write enable
//   o_mem_addr   code memory address (loader, or CPU while running)
//   o_mem_wdata  code memory write data
//   o_cpu_rst    high = CPU held in reset
//   o_loading    high while in LOAD
//   o_overrun    sticky: a byte arrived outside LOAD
// ============================================================================
module ice51_boot_ctrl
  import ice51_pkg::*;
#(
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit PRELOAD  = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic              i_reload,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_loading,
  output logic              o_overrun
);

  localparam int                c_drain_w     = cnt_width(DRAIN_CYCLES);
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] c_last_addr   = ADDR_W'(MEM_SIZE - 1);
  localparam boot_state_t       c_reset_state = PRELOAD ? ST_DRAIN : ST_LOAD;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  boot_state_t          r_state;
  logic [ADDR_W-1:0]    r_count;
  logic [c_drain_w-1:0] r_drain_cnt;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [7:0]           r_mem_wdata;
  logic                 r_cpu_rst;
  logic                 r_loading;
  logic                 r_overrun;

  // Next-state values
  boot_state_t          w_state_nxt;
  logic [ADDR_W-1:0]    w_count_nxt;
  logic [c_drain_w-1:0] w_drain_nxt;
  logic                 w_we_nxt;
  logic [ADDR_W-1:0]    w_wr_addr_nxt;
  logic [7:0]           w_wdata_nxt;
  logic                 w_overrun_nxt;

  // --------------------------------------------------------------------------
  // Register process
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_state     <= c_reset_state;
      r_count     <= '0;
      r_drain_cnt <= '0;
      r_mem_we    <= 1'b0;
      r_wr_addr   <= '0;
      r_mem_wdata <= 8'h00;
      r_cpu_rst   <= 1'b1;
      r_loading   <= ~PRELOAD;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_mem_we    <= w_we_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      // Status flags are derived from the state being entered so they
      // change in the same cycle as the state itself.
      r_cpu_rst   <= (w_state_nxt != ST_RUN);
      r_loading   <= (w_state_nxt == ST_LOAD);
      r_overrun   <= w_overrun_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath process
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_drain_nxt   = r_drain_cnt;
    w_we_nxt      = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wdata_nxt   = r_mem_wdata;
    w_overrun_nxt = r_overrun;

    unique case (r_state)
      ST_LOAD: begin
        if (i_rx_valid) begin
          w_we_nxt      = 1'b1;
          w_wr_addr_nxt = r_count;
          w_wdata_nxt   = i_rx_data;
          // The counter stops on the last address instead of wrapping;
          // it is cleared again only by reset or reload.
          if (r_count == c_last_addr) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (i_rx_valid) begin
          w_overrun_nxt = 1'b1;
        end
        if (r_drain_cnt == c_drain_last) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_drain_nxt = r_drain_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        // Reload takes priority: a coincident byte is neither written nor
        // flagged as an overrun.
        if (i_reload) begin
          w_state_nxt   = ST_LOAD;
          w_count_nxt   = '0;
          w_wr_addr_nxt = '0;
          w_overrun_nxt = 1'b0;
        end else if (i_rx_valid) begin
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = c_reset_state;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. The CPU owns the address port combinationally once running.
  // --------------------------------------------------------------------------
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = (r_state == ST_RUN) ? i_cpu_addr : r_wr_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_loading   = r_loading;
  assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ice51_boot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ice51_boot_ctrl
// Description : Self-checking bench for ice51_boot_ctrl. Random byte streams
//               and random gaps are fed to a loader instance; a PRELOAD
//               instance checks the skip-load path. Expected writes come from
//               the rule "byte k of a load goes to address k, one cycle after
//               it is accepted"; release timing from "CPU leaves reset three
//               cycles after the final byte".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ice51_boot_ctrl;
  import ice51_pkg::*;

  localparam int MEM_SIZE = DEFAULT_MEM_SIZE;
  localparam int ADDR_W   = DEFAULT_ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              nrst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              reload;
  logic [ADDR_W-1:0] cpu_addr;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              loading;
  logic              overrun;

  logic              p_mem_we;
  logic [ADDR_W-1:0] p_mem_addr;
  logic [7:0]        p_mem_wdata;
  logic              p_cpu_rst;
  logic              p_loading;
  logic              p_overrun;

  ice51_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .PRELOAD(1'b0)) u_dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .i_reload    (reload),
    .i_cpu_addr  (cpu_addr),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_rst   (cpu_rst),
    .o_loading   (loading),
    .o_overrun   (overrun)
  );

  ice51_boot_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W), .PRELOAD(1'b1)) u_dut_pre (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_rx_valid  (1'b0),
    .i_rx_data   (8'h00),
    .i_reload    (1'b0),
    .i_cpu_addr  (cpu_addr),
    .o_mem_we    (p_mem_we),
    .o_mem_addr  (p_mem_addr),
    .o_mem_wdata (p_mem_wdata),
    .o_cpu_rst   (p_cpu_rst),
    .o_loading   (p_loading),
    .o_overrun   (p_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_cnt = 0;   // bytes accepted in the current load
  int p_writes = 0;

  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;
  wr_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every observed write must be the oldest outstanding
  // expected write, at its due cycle.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr", 32'(mem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_cycle", cyc, e.due);
        check("wr_addr", 32'(mem_addr), e.addr);
        check("wr_data", 32'(mem_wdata), e.data);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("missed_wr", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    if (p_mem_we) p_writes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n random bytes with 0..max_gap idle cycles between them.
  task automatic load_image(input int n, input int max_gap);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) check("rst_before_last", 32'(cpu_rst), 32'd1);
      if (i == n / 2) check("loading_mid", 32'(loading), 32'd1);
      b = 8'($urandom);
      rx_valid = 1'b1;
      rx_data  = b;
      exp_q.push_back('{due: cyc + 1, addr: exp_cnt, data: int'(b)});
      exp_cnt++;
      tick();
      rx_valid = 1'b0;
      if (i != n - 1) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  // Called one cycle after the final byte was accepted. Optionally pokes a
  // byte during the drain window, which must only raise the overrun flag.
  task automatic check_release(input bit poke);
    check("drain_rst_t1", 32'(cpu_rst), 32'd1);
    check("drain_loading", 32'(loading), 32'd0);
    if (poke) begin
      rx_valid = 1'b1;
      rx_data  = 8'hA7;
    end
    tick();
    rx_valid = 1'b0;
    check("drain_rst_t2", 32'(cpu_rst), 32'd1);
    tick();
    check("run_rst_t3", 32'(cpu_rst), 32'd0);
    check("overrun_after_load", 32'(overrun), 32'(poke));
  endtask

  task automatic check_reset_outputs();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_loading", 32'(loading), 32'd1);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("pre_rst_cpu_rst", 32'(p_cpu_rst), 32'd1);
    check("pre_rst_loading", 32'(p_loading), 32'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    nrst     = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    cpu_addr = '0;
    repeat (3) tick();
    check_reset_outputs();

    // Release reset: PRELOAD instance runs after two edges, loader waits.
    nrst = 1'b0;
    tick();
    check("pre_rst_t1", 32'(p_cpu_rst), 32'd1);
    tick();
    check("pre_rst_t2", 32'(p_cpu_rst), 32'd0);
    cpu_addr = 9'h1A5;
    #1;
    check("pre_addr_mux", 32'(p_mem_addr), 32'h1A5);
    check("loading_idle", 32'(loading), 32'd1);

    // Full load with UART-like spacing between bytes
    load_image(MEM_SIZE, 12);
    check_release(1'b0);
    for (int k = 0; k < 4; k++) begin
      a = ADDR_W'($urandom);
      cpu_addr = a;
      #1;
      check("run_addr_mux", 32'(mem_addr), 32'(a));
    end

    // Byte while running: dropped, sticky overrun
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("run_overrun_set", 32'(overrun), 32'd1);
    repeat (3) tick();
    check("run_overrun_sticky", 32'(overrun), 32'd1);

    // Reload clears overrun and restarts the load at address 0
    reload = 1'b1;
    tick();
    reload = 1'b0;
    exp_cnt = 0;
    check("reload_overrun", 32'(overrun), 32'd0);
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_loading", 32'(loading), 32'd1);

    // Back-to-back bytes on every cycle
    load_image(MEM_SIZE, 0);
    check_release(1'b0);

    // Reload and byte in the same RUN cycle: reload wins
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    tick();
    reload   = 1'b0;
    rx_valid = 1'b0;
    exp_cnt  = 0;
    check("coinc_loading", 32'(loading), 32'd1);
    check("coinc_overrun", 32'(overrun), 32'd0);
    check("coinc_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (2) tick();

    // Partial load, then reset mid-load; load restarts at address 0
    load_image(100, 3);
    repeat (2) tick();
    nrst = 1'b1;
    tick();
    check_reset_outputs();
    nrst = 1'b0;
    exp_cnt = 0;
    tick();
    load_image(MEM_SIZE, 2);
    check_release(1'b1);

    repeat (5) tick();
    check("wr_q_empty", 32'(exp_q.size()), 32'd0);
    check("preload_no_writes", 32'(p_writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
